// File: rtl/noc_pkg.sv
// Shared router package.
// Holds the port-code encoding (also used by mux_5to1), the arbiter
// state type and a small mod-5 increment helper for port codes.
package noc_pkg;

  localparam int NUM_PORTS = 5;

  // Port codes; bit index in request vectors equals the code.
  typedef enum logic [2:0] {
    N = 3'd0,
    S = 3'd1,
    W = 3'd2,
    E = 3'd3,
    L = 3'd4
  } port_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Next port code, wrapping 4 -> 0.
  function automatic logic [2:0] inc_mod5(input logic [2:0] p);
    return (p >= 3'd4) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational rotate-priority picker over five requesters.
// Ports:
//   req_i   [4:0] request vector (bit index = port code)
//   start_i [2:0] highest-priority port code (0..4)
//   idx_o   [2:0] first requesting port code scanning start, start+1, ... mod 5
//   found_o       any request present
module rr_pick5
  import noc_pkg::*;
(
  input  logic [4:0] req_i,
  input  logic [2:0] start_i,
  output logic [2:0] idx_o,
  output logic       found_o
);

  logic [3:0] pos;

  always_comb begin
    idx_o   = 3'd0;
    found_o = 1'b0;
    pos     = 4'd0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pos = {1'b0, start_i} + 4'(i);
      if (pos >= 4'(NUM_PORTS)) pos = pos - 4'(NUM_PORTS);
      if (!found_o && req_i[pos[2:0]]) begin
        found_o = 1'b1;
        idx_o   = pos[2:0];
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_5.sv
// Five-input round-robin arbiter with wormhole (packet) locking for one
// router output port. The owner keeps the grant until its tail flit
// transfers (LOCK_EN=1) or for a single flit (LOCK_EN=0).
//
// Handshake: a flit moves (xfer_o=1) in a cycle where an owner is held
// (valid_o), the owner's req_i bit is high and out_ready_i is high. Nothing
// else is a transfer; requests from non-owners are ignored while locked.
//
// Ports:
//   clk_i, rst_i   clock (rising edge), async active-high reset
//   req_i  [4:0]   per-input flit request (bit = port code)
//   tail_i [4:0]   presented flit is a tail, qualified by req_i
//   out_ready_i    downstream accepts a flit this cycle
//   grant_o [4:0]  one-hot owner, zero when idle
//   sel_o   [2:0]  owner port code for mux_5to1, 000 when idle
//   valid_o        owner held
//   xfer_o         flit moves this cycle (combinational)
//   state_o, ptr_o debug view of the FSM state and priority pointer
module rr_arbiter_5
  import noc_pkg::*;
#(
  parameter bit LOCK_EN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] req_i,
  input  logic [4:0] tail_i,
  input  logic       out_ready_i,
  output logic [4:0] grant_o,
  output logic [2:0] sel_o,
  output logic       valid_o,
  output logic       xfer_o,
  output arb_state_e state_o,
  output logic [2:0] ptr_o
);

  arb_state_e state_q, state_d;
  logic [2:0] owner_q, owner_d;
  logic [2:0] ptr_q, ptr_d;

  logic [4:0] owner_bit;
  logic       locked;
  logic       xfer;
  logic       release_lock;

  logic [4:0] pick_req;
  logic [2:0] pick_start;
  logic [2:0] pick_idx;
  logic       pick_found;

  assign locked       = (state_q == LOCKED);
  assign owner_bit    = 5'b00001 << owner_q;
  assign xfer         = locked & req_i[owner_q] & out_ready_i;
  assign release_lock = xfer & (!LOCK_EN | tail_i[owner_q]);

  // One picker serves both cases: from IDLE it scans all requests from ptr;
  // on release it excludes the departing owner and starts just after it,
  // so the same input cannot re-win without passing through IDLE.
  always_comb begin
    pick_req   = req_i;
    pick_start = ptr_q;
    if (locked) begin
      pick_req   = req_i & ~owner_bit;
      pick_start = inc_mod5(owner_q);
    end
  end

  rr_pick5 u_pick (
    .req_i   (pick_req),
    .start_i (pick_start),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = LOCKED;
          owner_d = pick_idx;
        end
      end
      LOCKED: begin
        if (release_lock) begin
          ptr_d = inc_mod5(owner_q);
          if (pick_found) begin
            owner_d = pick_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 3'd0;
      ptr_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign valid_o = locked;
  assign grant_o = locked ? owner_bit : 5'b00000;
  assign sel_o   = locked ? owner_q : 3'd0;
  assign xfer_o  = xfer;
  assign state_o = state_q;
  assign ptr_o   = ptr_q;

endmodule

// File: tb/tb_rr_arbiter_5.sv
module tb_rr_arbiter_5;
  import noc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] req  = '0;
  logic [4:0] tail = '0;
  logic       rdy  = 1'b0;

  logic [4:0] grant0, grant1;
  logic [2:0] sel0, sel1, ptr0, ptr1;
  logic       valid0, valid1, xfer0, xfer1;
  arb_state_e st0, st1;

  rr_arbiter_5 #(.LOCK_EN(1'b1)) dut_lock (
    .clk_i(clk), .rst_i(rst), .req_i(req), .tail_i(tail), .out_ready_i(rdy),
    .grant_o(grant0), .sel_o(sel0), .valid_o(valid0), .xfer_o(xfer0),
    .state_o(st0), .ptr_o(ptr0)
  );

  rr_arbiter_5 #(.LOCK_EN(1'b0)) dut_nolock (
    .clk_i(clk), .rst_i(rst), .req_i(req), .tail_i(tail), .out_ready_i(rdy),
    .grant_o(grant1), .sel_o(sel1), .valid_o(valid1), .xfer_o(xfer1),
    .state_o(st1), .ptr_o(ptr1)
  );

  // ---------------- scoreboard ----------------
  localparam int W = 13;  // {grant, sel, valid, xfer, ptr}
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit         dut;   // 0: LOCK_EN=1 instance, 1: LOCK_EN=0 instance
    bit         rst;   // apply reset before this row
    string      name;
    logic [4:0] req;
    logic [4:0] tail;
    logic       rdy;
    logic [4:0] g;
    logic [2:0] s;
    logic       v;
    logic       x;
    logic [2:0] p;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit d, bit r, string nm, logic [4:0] rq, logic [4:0] tl,
                              logic rd, logic [4:0] g, logic [2:0] s, logic v,
                              logic x, logic [2:0] p);
    vec_t t;
    t.dut = d; t.rst = r; t.name = nm; t.req = rq; t.tail = tl; t.rdy = rd;
    t.g = g; t.s = s; t.v = v; t.x = x; t.p = p;
    vecs.push_back(t);
  endfunction

  task automatic check(input bit d, input string nm);
    logic [W-1:0] act;
    logic [W-1:0] e;
    act = d ? {grant1, sel1, valid1, xfer1, ptr1} : {grant0, sel0, valid0, xfer0, ptr0};
    e = exp_q.pop_front();
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: got grant=%b sel=%b valid=%b xfer=%b ptr=%0d, want grant=%b sel=%b valid=%b xfer=%b ptr=%0d",
               nm, act[12:8], act[7:5], act[4], act[3], act[2:0],
               e[12:8], e[7:5], e[4], e[3], e[2:0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    req = '0; tail = '0; rdy = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one cycle of inputs at negedge; outputs seen 1 time unit later
  // reflect the state from the previous edge plus combinational xfer.
  task automatic apply_vec(input vec_t t);
    if (t.rst) do_reset();
    @(negedge clk);
    req = t.req; tail = t.tail; rdy = t.rdy;
    exp_q.push_back({t.g, t.s, t.v, t.x, t.p});
    #1;
    check(t.dut, t.name);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- test ----------------
  initial begin
    //   dut rst name         req       tail      rdy grant     sel v  x  ptr
    // Two contenders, single-flit packets: N then W back to back, then idle.
    add(0, 1, "t1_idle",  5'b00101, 5'b00101, 1, 5'b00000, 0, 0, 0, 0);
    add(0, 0, "t1_n",     5'b00101, 5'b00101, 1, 5'b00001, 0, 1, 1, 0);
    add(0, 0, "t1_w",     5'b00100, 5'b00100, 1, 5'b00100, 2, 1, 1, 1);
    add(0, 0, "t1_end",   5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, 3);
    // N holds a 4-flit packet against S and L, then S, then L.
    add(0, 1, "t2_idle",  5'b10011, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);
    add(0, 0, "t2_f1",    5'b10011, 5'b00000, 1, 5'b00001, 0, 1, 1, 0);
    add(0, 0, "t2_f2",    5'b10011, 5'b00000, 1, 5'b00001, 0, 1, 1, 0);
    add(0, 0, "t2_f3",    5'b10011, 5'b00000, 1, 5'b00001, 0, 1, 1, 0);
    add(0, 0, "t2_f4",    5'b10011, 5'b00001, 1, 5'b00001, 0, 1, 1, 0);
    add(0, 0, "t2_s",     5'b10010, 5'b00010, 1, 5'b00010, 1, 1, 1, 1);
    add(0, 0, "t2_l",     5'b10000, 5'b10000, 1, 5'b10000, 4, 1, 1, 2);
    add(0, 0, "t2_end",   5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);
    // W owner stalled by out_ready and by its own request dropping.
    add(0, 0, "t3_req",   5'b00100, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);
    add(0, 0, "t3_hold1", 5'b00101, 5'b00000, 0, 5'b00100, 2, 1, 0, 0);
    add(0, 0, "t3_hold2", 5'b00001, 5'b00101, 0, 5'b00100, 2, 1, 0, 0);
    add(0, 0, "t3_hold3", 5'b00001, 5'b00000, 0, 5'b00100, 2, 1, 0, 0);
    add(0, 0, "t3_noreq", 5'b00001, 5'b00001, 1, 5'b00100, 2, 1, 0, 0);
    add(0, 0, "t3_wtail", 5'b00101, 5'b00100, 1, 5'b00100, 2, 1, 1, 0);
    add(0, 0, "t3_n",     5'b00001, 5'b00001, 1, 5'b00001, 0, 1, 1, 3);
    add(0, 0, "t3_end",   5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, 1);
    // E moves ptr to 4; L wins over N, then N; N re-wins only via IDLE.
    add(0, 0, "t4_ereq",  5'b01000, 5'b01000, 1, 5'b00000, 0, 0, 0, 1);
    add(0, 0, "t4_e",     5'b01000, 5'b01000, 1, 5'b01000, 3, 1, 1, 1);
    add(0, 0, "t4_lreq",  5'b10001, 5'b10001, 1, 5'b00000, 0, 0, 0, 4);
    add(0, 0, "t4_l",     5'b10001, 5'b10001, 1, 5'b10000, 4, 1, 1, 4);
    add(0, 0, "t4_n",     5'b00001, 5'b00001, 1, 5'b00001, 0, 1, 1, 0);
    add(0, 0, "t4_gap",   5'b00001, 5'b00001, 1, 5'b00000, 0, 0, 0, 1);
    add(0, 0, "t4_rewin", 5'b00001, 5'b00001, 1, 5'b00001, 0, 1, 1, 1);
    add(0, 0, "t4_end",   5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, 1);
    // LOCK_EN=0: every flit re-arbitrates, all five requesting.
    add(1, 1, "t5_idle",  5'b11111, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);
    add(1, 0, "t5_0",     5'b11111, 5'b00000, 1, 5'b00001, 0, 1, 1, 0);
    add(1, 0, "t5_1",     5'b11111, 5'b00000, 1, 5'b00010, 1, 1, 1, 1);
    add(1, 0, "t5_2",     5'b11111, 5'b00000, 1, 5'b00100, 2, 1, 1, 2);
    add(1, 0, "t5_3",     5'b11111, 5'b00000, 1, 5'b01000, 3, 1, 1, 3);
    add(1, 0, "t5_4",     5'b11111, 5'b00000, 1, 5'b10000, 4, 1, 1, 4);
    add(1, 0, "t5_5",     5'b11111, 5'b00000, 1, 5'b00001, 0, 1, 1, 0);
    add(1, 0, "t5_stall", 5'b11111, 5'b00000, 0, 5'b00010, 1, 1, 0, 1);
    add(1, 0, "t5_go",    5'b11111, 5'b00000, 1, 5'b00010, 1, 1, 1, 1);

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Asynchronous reset in the middle of a W packet.
    begin
      vec_t t;
      t.dut = 0; t.rst = 1; t.name = "r_idle"; t.req = 5'b00100; t.tail = 5'b00000;
      t.rdy = 1; t.g = 5'b00000; t.s = 0; t.v = 0; t.x = 0; t.p = 0;
      apply_vec(t);
      t.rst = 0; t.name = "r_flit"; t.g = 5'b00100; t.s = 3'd2; t.v = 1; t.x = 1;
      apply_vec(t);
      @(posedge clk);
      #2;
      req = '0; rdy = 1'b0; tail = '0;
      rst = 1'b1;
      #1;
      exp_q.push_back({5'b00000, 3'd0, 1'b0, 1'b0, 3'd0});
      check(0, "r_async");
      n_cmp++;
      if (st0 !== IDLE) begin
        n_err++;
        $display("FAIL r_async_state: got %0d, want %0d", st0, IDLE);
      end
      @(negedge clk);
      rst = 1'b0;
      t.name = "r_sreq"; t.req = 5'b00010; t.tail = 5'b00010;
      t.g = 5'b00000; t.s = 0; t.v = 0; t.x = 0; t.p = 0;
      apply_vec(t);
      t.name = "r_s"; t.g = 5'b00010; t.s = 3'd1; t.v = 1; t.x = 1;
      apply_vec(t);
    end

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
